// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the EX stage.
// MULT/MULTU use shift-add and DIV/DIVU use restoring shift-subtract, one step per clock.
// The step runs on operand magnitudes; the sign is corrected in FIXUP before HI/LO are written.
// stall_req holds the pipeline from the accepting cycle until the result is committed.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // Working registers. They are loaded when an op is accepted, so they need no reset.
  logic             is_div;
  logic             is_signed;
  logic             neg_a;
  logic             neg_b;
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] low;
  logic [WIDTH:0]   acc;

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] low_nxt;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;
  logic [2*WIDTH-1:0] prod_fix;

  // The magnitude of 0x80000000 wraps to 0x80000000, which reads correctly as unsigned 2^31.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                              input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] v,
                                               input logic n);
    return n ? -v : v;
  endfunction

  assign accept    = (state == IDLE) && start && !flush;
  assign busy      = (state != IDLE);
  assign stall_req = accept || (state == CALC) || (state == FIXUP);

  // Perform one iteration step.
  // mul: {acc,low} is the running product, with low starting as the multiplier.
  // div: acc is the partial remainder, and low moves from dividend to quotient.
  always_comb begin
    add_sum = low[0] ? (acc + {1'b0, b_mag}) : acc;
    rem_sh  = {acc[WIDTH-1:0], low[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_mag};
    acc_nxt = {1'b0, add_sum[WIDTH:1]};
    low_nxt = {add_sum[0], low[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_nxt = diff;
        low_nxt = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh;
        low_nxt = {low[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign-correct the raw result.
  // Divide by zero bypasses the correction and reports all-ones / dividend.
  always_comb begin
    prod_fix = neg_2w({acc[WIDTH-1:0], low}, is_signed && (neg_a ^ neg_b));
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        hi_fix = a_raw;
        lo_fix = '1;
      end else begin
        hi_fix = neg_w(acc[WIDTH-1:0], is_signed && neg_a);
        lo_fix = neg_w(low, is_signed && (neg_a ^ neg_b));
      end
    end
  end

  // Load the operands when an op is accepted, then step the datapath once per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div    <= op[1];
      is_signed <= ~op[0];
      neg_a     <= ~op[0] & src_a[WIDTH-1];
      neg_b     <= ~op[0] & src_b[WIDTH-1];
      b_zero    <= (src_b == '0);
      a_raw     <= src_a;
      b_mag     <= abs_val(src_b, ~op[0]);
      low       <= abs_val(src_a, ~op[0]);
      acc       <= '0;
    end else if (state == CALC) begin
      acc <= acc_nxt;
      low <= low_nxt;
    end
  end

  // Control FSM.
  // hi/lo commit on the FIXUP exit edge, and done/div_by_zero are registered one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CALC;
            count <= '0;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else if (count == CNT_W'(WIDTH - 1)) begin
            state <= FIXUP;
          end else begin
            count <= count + 1'b1;
          end
        end
        FIXUP: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi          <= hi_fix;
            lo          <= lo_fix;
            done        <= 1'b1;
            div_by_zero <= is_div & b_zero;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: products, quotients, sign rules, divide by zero,
// latency, stall timing, flush and asynchronous reset.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  // Results captured by do_op.
  int   r_lat;
  logic r_stall0;
  logic r_stall_bad;
  logic r_stall_done;
  logic r_dbz;
  logic r_busy_done;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .stall_req(stall_req), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A start while the unit is busy would be an illegal pipeline state.
  always @(posedge clk) begin
    if (reset && start && busy) begin
      errors++;
      $display("FAIL start_while_busy got start=1 busy=1 want start=0");
    end
  end

  // Issue one op in cycle 0 and follow it until done, recording the stall behaviour.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    r_lat = -1; r_stall_bad = 1'b0; r_stall_done = 1'b1; r_dbz = 1'b0; r_busy_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 r_stall0 = stall_req;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (done) begin
        r_lat = cyc; r_dbz = div_by_zero; r_stall_done = stall_req; r_busy_done = busy;
        break;
      end
      if (!stall_req) r_stall_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    #22;
    checks++;
    if ({busy, stall_req, done, div_by_zero} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {busy, stall_req, done, div_by_zero});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_multu_max;
    do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (r_lat !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", r_lat); end
    checks++;
    if ({r_stall0, r_stall_bad, r_stall_done, r_busy_done} !== 4'b1001) begin
      errors++;
      $display("FAIL multu_stall got s0=%b gap=%b sdone=%b bdone=%b want 1 0 0 1",
               r_stall0, r_stall_bad, r_stall_done, r_busy_done);
    end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      errors++; $display("FAIL multu_max got %h_%h want FFFFFFFE_00000001", hi, lo);
    end
    do_op(MULTU, 32'h12345678, 32'h00000010);
    checks++;
    if ({hi, lo} !== 64'h00000001_23456780) begin
      errors++; $display("FAIL multu_shift got %h_%h want 00000001_23456780", hi, lo);
    end
  endtask

  task automatic test_mult_signed;
    do_op(MULT, 32'h80000000, 32'h80000000);
    checks++;
    if ({hi, lo} !== 64'h40000000_00000000) begin
      errors++; $display("FAIL mult_min_sq got %h_%h want 40000000_00000000", hi, lo);
    end
    do_op(MULT, 32'hFFFFFFFD, 32'h00000007);
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      errors++; $display("FAIL mult_neg got %h_%h want FFFFFFFF_FFFFFFEB", hi, lo);
    end
  endtask

  task automatic test_div;
    do_op(DIV, 32'hFFFFFFF9, 32'h00000002);
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL div_neg7_2 got %h_%h want FFFFFFFF_FFFFFFFD", hi, lo);
    end
    do_op(DIV, 32'h00000007, 32'hFFFFFFFE);
    checks++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin
      errors++; $display("FAIL div_7_neg2 got %h_%h want 00000001_FFFFFFFD", hi, lo);
    end
    do_op(DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if ({hi, lo, r_dbz} !== {64'h00000000_80000000, 1'b0}) begin
      errors++; $display("FAIL div_wrap got %h_%h dbz=%b want 00000000_80000000 dbz=0", hi, lo, r_dbz);
    end
    do_op(DIVU, 32'd100, 32'd7);
    checks++;
    if ({hi, lo} !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL divu_100_7 got %h_%h want 00000002_0000000E", hi, lo);
    end
  endtask

  task automatic test_div_by_zero;
    do_op(DIVU, 32'd5, 32'd0);
    checks++;
    if ({hi, lo, r_dbz} !== {64'h00000005_FFFFFFFF, 1'b1} || r_lat !== 34) begin
      errors++;
      $display("FAIL divu_zero got %h_%h dbz=%b lat=%0d want 00000005_FFFFFFFF dbz=1 lat=34",
               hi, lo, r_dbz, r_lat);
    end
    do_op(DIV, 32'hFFFFFFFB, 32'd0);
    checks++;
    if ({hi, lo, r_dbz} !== {64'hFFFFFFFB_FFFFFFFF, 1'b1}) begin
      errors++; $display("FAIL div_zero got %h_%h dbz=%b want FFFFFFFB_FFFFFFFF dbz=1", hi, lo, r_dbz);
    end
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++; $display("FAIL dbz_pulse got %b want 0 after done", div_by_zero);
    end
  endtask

  task automatic test_flush;
    logic saw_done;
    int cyc;
    do_op(MULT, 32'hFFFFFFFD, 32'h00000007);
    // A start with flush in IDLE must not be accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b want 0", stall_req); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", busy); end
    // Accept DIVU 100/7 in cycle 0 and flush it in cycle 10.
    saw_done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 10; cyc++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, stall_req} !== 2'b00) begin
      errors++; $display("FAIL flush_calc got busy=%b stall=%b want 0 0", busy, stall_req);
    end
    for (cyc = 11; cyc < 40; cyc++) begin
      if (done) saw_done = 1'b1;
      if (cyc == 11) @(negedge clk);
      else break;
    end
    checks++;
    if (saw_done !== 1'b0 || {hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      errors++;
      $display("FAIL flush_hold got done=%b %h_%h want 0 FFFFFFFF_FFFFFFEB", saw_done, hi, lo);
    end
    // Cycle 12: a new start is accepted.
    start = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin errors++; $display("FAIL restart_stall got %b want 1", stall_req); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 34 || {hi, lo} !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL restart_result got lat=%0d %h_%h want 34 00000002_0000000E", cyc, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    start = 1'b1; op = MULTU; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    // Now in cycle 20, away from any rising edge.
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, stall_req, done} !== 3'b000 || {hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL async_reset got busy=%b stall=%b done=%b %h_%h want 000 0_0",
               busy, stall_req, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    do_op(MULTU, 32'd3, 32'd5);
    checks++;
    if (r_lat !== 34 || {hi, lo} !== 64'h00000000_0000000F) begin
      errors++; $display("FAIL post_reset got lat=%0d %h_%h want 34 0_F", r_lat, hi, lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_by_zero();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
